fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction fetch stage between the instruction ROM and the CPU core.
- Generates word addresses to the synchronous ROM (1-cycle read latency) and buffers the returned words with their PCs in a small prefetch FIFO.
- Presents instructions to the core over a valid/ready handshake.
- Accepts a redirect (jump/branch) from the core, flushing all prefetched and in-flight words.

Parameters:
- ADDR_WIDTH, 7, width of word address / PC
- DATA_WIDTH, 32, instruction width
- DEPTH, 4, prefetch FIFO entries (power of two, >= 2)
- LAST_PC, 2**ADDR_WIDTH-1, highest fetchable address; fetch halts after issuing it

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- rom_addr  out  ADDR_WIDTH  word address to ROM
- rom_q  in  DATA_WIDTH  ROM data, valid one cycle after rom_addr sampled
- instr_valid  out  1  head FIFO entry valid
- instr_data  out  DATA_WIDTH  head instruction
- instr_pc  out  ADDR_WIDTH  PC of head instruction
- instr_ready  in  1  core accepts head this cycle
- redirect_valid  in  1  core requests PC change
- redirect_pc  in  ADDR_WIDTH  new fetch PC
- halted  out  1  LAST_PC issued and no redirect since

Behaviour:
- Reset (async assert, sync release): pc=0, FIFO empty, in-flight=0, halted=0, instr_valid=0, rom_addr=0.
- Issue: fires when !halted && (fifo_count + inflight) < DEPTH && !redirect_valid. On issue: rom_addr=pc (combinational from pc register), inflight<=1, inflight_pc<=pc, pc<=pc+1.
- Response: cycle after issue, rom_q and inflight_pc written to FIFO tail unless flushed; inflight clears unless a new issue occurs that cycle. Throughput 1 instr/cycle steady-state.
- Latency: reset-release to first instr_valid = 2 cycles (issue, then capture).
- Handshake: transfer when instr_valid && instr_ready. instr_data/instr_pc stable while valid && !ready. instr_valid never depends on instr_ready.
- Simultaneous push and pop: allowed at any occupancy, count unchanged. Full: no push can occur, guaranteed by the issue credit rule. Empty: instr_valid=0, no bypass.
- Redirect (priority over everything): same edge, FIFO cleared, in-flight response discarded, pc<=redirect_pc, halted<=0. No issue that cycle. First redirected instr valid 2 cycles later. A pop coinciding with redirect is ignored; the core must not count it.
- Halt: issuing pc==LAST_PC sets halted<=1, with no wrap to 0. Buffered instructions still drain. Only reset or redirect clears halted.
- PC arithmetic: modulo 2**ADDR_WIDTH. redirect_pc > LAST_PC sets halted next cycle without issuing.
- Reset mid-operation: all state cleared immediately; in-flight ROM data ignored.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetched (32, count of accepted handshakes) and perf_flushes (32, count of redirects). Both are reset to 0, wrap at 2**32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package fetch_pkg: ADDR_WIDTH/DATA_WIDTH defaults, FIFO entry struct {pc, data}, helper constant for the count width $clog2(DEPTH)+1.
- Sub-module fetch_fifo: synchronous FIFO with push, pop, flush, count, head outputs. fetch_unit holds pc, in-flight tracking, halt and the optional counters.

Test Plan:
- Reset release, ROM[i]=0x1000+i, ready=1 always -> instr_valid rises cycle 2; instr_pc 0,1,2… one per cycle; data 0x1000,0x1001….
- ready=0 for 10 cycles -> exactly DEPTH=4 entries buffered; rom_addr holds at 4; head stays pc0/0x1000. On ready=1, 4 drain back-to-back, then fetch resumes at pc4.
- Redirect to 0x20 while FIFO holds 3 entries and one in flight -> next instr_valid=1 two cycles later with instr_pc=0x20; pcs 1..4 never delivered.
- LAST_PC=5, ready=1 -> pcs 0..5 delivered; halted=1 after pc5 issue; rom_addr stops; instr_valid=0 afterwards.
- rst_n asserted mid-stream with FIFO at 2 -> instr_valid=0 immediately (async); after release, fetch restarts at pc0.
- FETCH_PERF_CNT_EN defined, 7 accepts and 2 redirects -> perf_fetched=7, perf_flushes=2.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared defaults and types for the instruction fetch stage.
//   DEFAULT_ADDR_WIDTH / DEFAULT_DATA_WIDTH / DEFAULT_DEPTH : parameter defaults
//   fetch_entry_t : prefetch FIFO entry {pc, data} at the default widths
//   count_width() : width of an occupancy counter able to hold 0..depth
package fetch_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 7;
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_DEPTH      = 4;

    typedef struct packed {
        logic [DEFAULT_ADDR_WIDTH-1:0] pc;
        logic [DEFAULT_DATA_WIDTH-1:0] data;
    } fetch_entry_t;

    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous show-ahead FIFO for prefetched instructions.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   push         : write push_entry at the tail this cycle
//   push_entry   : entry to write
//   pop          : drop the head entry this cycle (ignored when empty)
//   flush        : discard all entries; overrides push and pop
//   count        : current occupancy (0..DEPTH)
//   head         : oldest entry, valid whenever count != 0
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int ENTRY_WIDTH = $bits(fetch_entry_t)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [ENTRY_WIDTH-1:0]        push_entry,
    input  logic                          pop,
    input  logic                          flush,
    output logic [count_width(DEPTH)-1:0] count,
    output logic [ENTRY_WIDTH-1:0]        head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = count_width(DEPTH);

    logic [ENTRY_WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_reg;
    logic [PTR_W-1:0]       rd_ptr_reg;
    logic [CW-1:0]          count_reg;
    logic                   pop_ok;

    assign pop_ok = pop && (count_reg != '0);

    // Storage carries no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_reg[wr_ptr_reg] <= push_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop_ok})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign count = count_reg;
    assign head  = mem_reg[rd_ptr_reg];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage between a synchronous ROM (1-cycle read
// latency) and the CPU core. Issues word addresses, buffers returned words with
// their PCs in a prefetch FIFO and hands them to the core over valid/ready.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   rom_addr / rom_q            : ROM address out, data back one cycle later
//   instr_valid/data/pc, ready  : head-of-FIFO handshake towards the core
//   redirect_valid, redirect_pc : PC change request; flushes all prefetched work
//   halted                      : LAST_PC issued and no redirect since
// Optional build macro FETCH_PERF_CNT_EN adds:
//   perf_fetched : accepted handshakes, perf_flushes : redirects (both wrap at 2**32)
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int                    DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int                    DEPTH      = DEFAULT_DEPTH,
    parameter logic [ADDR_WIDTH-1:0] LAST_PC    = {ADDR_WIDTH{1'b1}}
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_q,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  instr_ready,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           perf_fetched,
    output logic [31:0]           perf_flushes
`endif
);

    localparam int CW = count_width(DEPTH);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    logic [ADDR_WIDTH-1:0] pc_reg;
    logic [ADDR_WIDTH-1:0] inflight_pc_reg;
    logic                  inflight_reg;
    logic                  halted_reg;

    logic [CW-1:0]         fifo_count;
    logic [CW:0]           credits_used;
    logic                  pc_beyond_last;
    logic                  issue;
    logic                  push;
    logic                  pop;
    entry_t                push_entry;
    entry_t                head_entry;

    // Widened compare keeps it meaningful when LAST_PC is the top address.
    assign pc_beyond_last = {1'b0, pc_reg} > {1'b0, LAST_PC};

    // Every buffered word and the one in flight hold a FIFO slot, so a
    // returning word always finds room.
    assign credits_used = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_reg};

    assign issue = !halted_reg && !redirect_valid && !pc_beyond_last &&
                   (credits_used < (CW+1)'(DEPTH));

    assign push = inflight_reg && !redirect_valid;
    assign pop  = instr_valid && instr_ready && !redirect_valid;

    assign push_entry = '{pc: inflight_pc_reg, data: rom_q};

    fetch_fifo #(
        .DEPTH       (DEPTH),
        .ENTRY_WIDTH ($bits(entry_t))
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .count      (fifo_count),
        .head       (head_entry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg          <= '0;
            inflight_pc_reg <= '0;
            inflight_reg    <= 1'b0;
            halted_reg      <= 1'b0;
        end else if (redirect_valid) begin
            pc_reg       <= redirect_pc;
            inflight_reg <= 1'b0;
            halted_reg   <= 1'b0;
        end else begin
            inflight_reg <= issue;
            if (issue) begin
                inflight_pc_reg <= pc_reg;
                // PC parks on LAST_PC rather than wrapping to 0.
                if (pc_reg == LAST_PC) begin
                    halted_reg <= 1'b1;
                end else begin
                    pc_reg <= pc_reg + ADDR_WIDTH'(1);
                end
            end else if (pc_beyond_last) begin
                halted_reg <= 1'b1;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_reg;
    logic [31:0] perf_flushes_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_reg <= '0;
            perf_flushes_reg <= '0;
        end else begin
            if (pop) begin
                perf_fetched_reg <= perf_fetched_reg + 32'd1;
            end
            if (redirect_valid) begin
                perf_flushes_reg <= perf_flushes_reg + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_reg;
    assign perf_flushes = perf_flushes_reg;
`endif

    assign rom_addr    = pc_reg;
    assign instr_valid = (fifo_count != '0);
    assign instr_data  = head_entry.data;
    assign instr_pc    = head_entry.pc;
    assign halted      = halted_reg;

endmodule
